// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: opcode encoding, FSM states,
// iteration count and small decode helpers used by EX and ID.
package mdu_pkg;

   // MDU opcode as produced by the ID stage decoder
   typedef enum logic [2:0] {
      MDU_NONE  = 3'b000,
      MDU_MULT  = 3'b001,
      MDU_MULTU = 3'b010,
      MDU_DIV   = 3'b011,
      MDU_DIVU  = 3'b100,
      MDU_MTHI  = 3'b101,
      MDU_MTLO  = 3'b110
   } mdu_op_e;

   // iterative engine states
   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_RUN  = 2'b01,
      MDU_FIX  = 2'b10
   } mdu_state_e;

   // one shift/add or shift/subtract step per operand bit
   localparam int unsigned MDU_ITER = 32;

   // true for the opcodes that occupy the iterative engine
   function automatic logic mdu_is_muldiv(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   // true for the opcodes that treat operands as two's complement
   function automatic logic mdu_is_signed(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   // true for the division opcodes
   function automatic logic mdu_is_div(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO.
// Operands are reduced to magnitudes on entry, processed unsigned over
// MDU_ITER cycles in one shared 2*WIDTH accumulator, and sign-corrected
// in a final FIX cycle that also writes HI/LO.
module ex_muldiv_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   mdu_op_e           op;
   mdu_state_e        state, state_next;
   logic [5:0]        cnt;
   logic              accept;

   // operation context latched on accept
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   raw_a;     // unmodified dividend for divide-by-zero
   logic               is_div;
   logic               neg_res;   // product / quotient is negative
   logic               neg_rem;   // remainder takes the dividend's sign
   logic               div_zero;

   // entry magnitudes
   logic               sgn_op;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   // per-iteration datapath
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic               no_uf;
   logic [WIDTH-1:0]   rem_new;
   logic [2*WIDTH-1:0] acc_step;

   // sign-corrected results
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   logic [WIDTH-1:0]   hi_res, lo_res;

   assign op = mdu_op_e'(MDUOp);

   // operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
   always_comb begin
      sgn_op = mdu_is_signed(op);
      a_neg  = sgn_op & SrcA[WIDTH-1];
      b_neg  = sgn_op & SrcB[WIDTH-1];
      a_mag  = a_neg ? (~SrcA + 1'b1) : SrcA;
      b_mag  = b_neg ? (~SrcB + 1'b1) : SrcB;
   end

   // next-state and stall request
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      busy       = 1'b0;
      case (state)
         MDU_IDLE: begin
            accept = start & mdu_is_muldiv(op) & ~flush;
            if (accept) state_next = MDU_RUN;
         end
         MDU_RUN: begin
            busy = 1'b1;
            if (cnt == '0) state_next = MDU_FIX;
         end
         MDU_FIX: state_next = MDU_IDLE;
         default: state_next = MDU_IDLE;
      endcase
      busy = busy | accept;
      if (flush) state_next = MDU_IDLE;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= MDU_IDLE;
      else     state <= state_next;
   end

   // one shift-add (multiply) or restoring shift-subtract (divide) step
   always_comb begin
      mul_add  = acc[0] ? opnd : '0;
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      no_uf    = (rem_sh >= {1'b0, opnd});
      // result is below the divisor, so WIDTH-bit wraparound subtraction is exact
      rem_new  = no_uf ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
      acc_step = is_div ? {rem_new, acc[WIDTH-2:0], no_uf}
                        : {mul_sum, acc[WIDTH-1:1]};
   end

   // sign correction and HI/LO selection for the FIX cycle
   always_comb begin
      prod_fix = neg_res ? (~acc + 1'b1) : acc;
      quot_fix = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      hi_res   = prod_fix[2*WIDTH-1:WIDTH];
      lo_res   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (div_zero) begin
            hi_res = raw_a;
            lo_res = '1;
         end else begin
            hi_res = rem_fix;
            lo_res = quot_fix;
         end
      end
   end

   // datapath: operand latch, iteration, HI/LO write and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         raw_a    <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         HI       <= '0;
         LO       <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!flush) begin
            case (state)
               MDU_IDLE: begin
                  if (accept) begin
                     cnt      <= 6'(MDU_ITER - 1);
                     is_div   <= mdu_is_div(op);
                     neg_res  <= a_neg ^ b_neg;
                     neg_rem  <= a_neg;
                     raw_a    <= SrcA;
                     div_zero <= mdu_is_div(op) && (SrcB == '0);
                     if (mdu_is_div(op)) begin
                        opnd <= b_mag;
                        acc  <= {{WIDTH{1'b0}}, a_mag};
                     end else begin
                        opnd <= a_mag;
                        acc  <= {{WIDTH{1'b0}}, b_mag};
                     end
                  end else if (start && op == MDU_MTHI) begin
                     HI <= SrcA;
                  end else if (start && op == MDU_MTLO) begin
                     LO <= SrcA;
                  end
               end
               MDU_RUN: begin
                  acc <= acc_step;
                  if (cnt != '0) cnt <= cnt - 6'd1;
               end
               MDU_FIX: begin
                  HI   <= hi_res;
                  LO   <= lo_res;
                  done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: result values, stall/done timing,
// MTHI/MTLO, flush/reset aborts and a held start request.
module tb_ex_muldiv_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  MDUOp;
   logic [31:0] SrcA, SrcB;
   logic        flush;
   logic        busy, done;
   logic [31:0] HI, LO;

   int tests = 0;
   int fails = 0;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .MDUOp (MDUOp),
      .SrcA  (SrcA),
      .SrcB  (SrcB),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // issue one mul/div op in cycle 0 and observe cycles 1..40
   task automatic run_op(input string tag, input mdu_op_e opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit hold);
      int busy_n, first_low, done_n, done_c;
      logic [31:0] hi_s, lo_s;
      logic b0;
      @(posedge clk); #1;
      start = 1'b1; MDUOp = opc; SrcA = a; SrcB = b;
      #3; b0 = busy;
      busy_n = 0; first_low = -1; done_n = 0; done_c = -1; hi_s = '0; lo_s = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (!hold || c >= 34) begin start = 1'b0; MDUOp = MDU_NONE; end
         #3;
         if (busy) busy_n++;
         else if (first_low < 0) first_low = c;
         if (done) begin done_n++; done_c = c; hi_s = HI; lo_s = LO; end
      end
      check({tag, "_busy_c0"}, 64'(b0), 64'd1);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
      check({tag, "_busy_drop"}, 64'(first_low), 64'd33);
      check({tag, "_done_count"}, 64'(done_n), 64'd1);
      check({tag, "_done_cycle"}, 64'(done_c), 64'd34);
      check({tag, "_hi"}, 64'(hi_s), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo_s), 64'(exp_lo));
   endtask

   // MTHI/MTLO: no stall, one-edge write latency
   task automatic move_to(input string tag, input mdu_op_e opc, input logic [31:0] d,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      @(posedge clk); #1;
      start = 1'b1; MDUOp = opc; SrcA = d; SrcB = '0;
      #3;
      check({tag, "_busy"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; MDUOp = MDU_NONE;
      #3;
      check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
      check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
   endtask

   // DIVU 100/3 aborted in cycle 10 by flush or reset
   task automatic abort_op(input string tag, input bit use_rst,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int done_n;
      logic b11;
      @(posedge clk); #1;
      start = 1'b1; MDUOp = MDU_DIVU; SrcA = 32'd100; SrcB = 32'd3;
      done_n = 0; b11 = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         start = 1'b0; MDUOp = MDU_NONE;
         if (use_rst) rst = (c == 10);
         else         flush = (c == 10);
         #3;
         if (c == 11) b11 = busy;
         if (done) done_n++;
      end
      check({tag, "_busy_after"}, 64'(b11), 64'd0);
      check({tag, "_no_done"}, 64'(done_n), 64'd0);
      check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
      check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; MDUOp = MDU_NONE; SrcA = '0; SrcB = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #3;
      check("reset_hi", 64'(HI), 64'd0);
      check("reset_lo", 64'(LO), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);

      run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult_minmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_7_m2", MDU_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_by0", MDU_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
      run_op("div_neg_by0", MDU_DIV, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
      run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

      move_to("mthi", MDU_MTHI, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000);
      move_to("mtlo", MDU_MTLO, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D);

      // start alongside flush in IDLE is dropped
      @(posedge clk); #1;
      start = 1'b1; MDUOp = MDU_MULT; SrcA = 32'd9; SrcB = 32'd9; flush = 1'b1;
      #3;
      check("flush_start_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; MDUOp = MDU_NONE; flush = 1'b0;
      #3;
      check("flush_start_idle", 64'(busy), 64'd0);
      check("flush_start_lo", 64'(LO), 64'hCAFE_F00D);

      abort_op("flush_mid", 1'b0, 32'h1234_5678, 32'hCAFE_F00D);
      abort_op("rst_mid", 1'b1, 32'h0000_0000, 32'h0000_0000);

      run_op("mult_held", MDU_MULT, 32'd5, 32'd6, 32'h0000_0000, 32'd30, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the EX stage of the pipelined CPU. It consumes the operands and MDU opcode from the ID/EX register outputs and computes MULT/MULTU/DIV/DIVU results over 33 cycles. Results go into architectural HI/LO registers. While an operation runs, the unit drives `busy` into the hazard logic, which stalls ID/EX and upstream stages.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  valid MDU op present in EX
- `MDUOp`  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- `SrcA`  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data)
- `SrcB`  in  WIDTH  rt value (divisor / multiplier)
- `flush`  in  1  abort in-flight op (exception/redirect)
- `busy`  out  1  combinational stall request to hazard unit
- `done`  out  1  registered one-cycle pulse after HI/LO update from mul/div
- `HI`  out  WIDTH  HI register
- `LO`  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX. 6-bit iteration counter.
- **IDLE:**
  - On `start` with MULT/MULTU/DIV/DIVU, latch operand magnitudes and result-sign flags, set counter = 31, and go to RUN.
  - Signed ops take the absolute value of the operands. The magnitude of 0x80000000 is 2^31, held unsigned.
- **MTHI/MTLO in IDLE:** write `SrcA` to HI/LO at the next edge; no busy, no state change.
- **RUN:** one iteration per cycle.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring; shift the remainder left, subtract the divisor if it does not underflow, and shift in the quotient bit.
  - At counter = 0, go to FIX.
- **FIX:**
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] / remainder, LO = product[31:0] / quotient.
  - Return to IDLE; `done` = 1 in the following cycle.
- **Divide by zero:** LO = 0xFFFFFFFF, HI = SrcA (unmodified dividend), for both DIV and DIVU.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0.
- `start` in RUN or FIX is ignored; operands are not re-latched.
- **`flush`:** any state goes to IDLE at the next edge. HI/LO are unchanged, `done` stays 0, and a same-cycle `start` is ignored.
- **`rst`:** state IDLE, counter 0, HI = LO = 0, `done` = 0. `rst` takes priority over `flush` and `start`, and aborts mid-operation.

## Timing
- `busy = (state==RUN) | (state==IDLE & start & MDUOp in {MULT,MULTU,DIV,DIVU} & !flush)`.
- Start is sampled in cycle 0; RUN covers cycles 1–32 and FIX is cycle 33.
  - `busy` is high in cycles 0–32 and low in FIX.
  - The stalled instruction therefore leaves EX at the end of cycle 33, the same edge that writes HI/LO.
  - No re-trigger occurs in cycle 34.
- An MFHI/MFLO in EX in cycle 34 reads the new HI/LO (registered outputs).
- MTHI/MTLO have 1-edge latency; MFHI in the next cycle sees the new value.
- `done` is high in cycle 34 only.

## Structure
- Shared package `mdu_pkg`:
  - MDUOp encodings (`MDU_NONE`…`MDU_MTLO`)
  - state encoding (`MDU_IDLE`, `MDU_RUN`, `MDU_FIX`)
  - iteration count constant (`MDU_ITER = 32`)
- The ID stage decoder imports the same MDUOp encoding.
- Single module; no sub-module. The shift datapaths are small enough to share one 64-bit accumulator register between multiply and divide.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → busy for 33 cycles; cycle 34: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, done = 1 for one cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 7. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MTHI 0x12345678 while IDLE → busy stays 0; HI = 0x12345678 next cycle, LO unchanged.
- Start DIVU 100/3, assert `flush` in cycle 10 → IDLE next cycle, busy 0, HI/LO keep their prior values, no done pulse. Repeat with `rst` in cycle 10 → HI = LO = 0.
- Hold `start` + MULT 5×6 for 34 cycles (pipeline-stall model) → exactly one operation; HI = 0, LO = 30; `start` in FIX not re-accepted.
